// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, Tick on the last count.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  output logic Tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running count within a bit period; parked at 0 while disabled.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (!Enable || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign Tick = Enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: holding register + shift register, start/data/parity/stop framing.
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] TxData,
  input  logic       TxWrite,
  output logic       TxReady,
  output logic       TxD,
  output logic       TxBusy,
  output logic       TxDone,
  output logic       TxOverrun
);

  import uart_pkg::*;

  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
  localparam bit PAR_EN  = (PARITY_EN != 0);
  localparam bit PAR_ODD = (PARITY_ODD != 0);

  tx_state_e              state_q, state_next;
  logic [DATA_BITS-1:0]   hold_q;
  logic [DATA_BITS-1:0]   shift_q, shift_next;
  logic                   par_q, par_next;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_next;
  logic                   tx_ready_q, tx_busy_q, tx_d_q, overrun_q;
  logic                   txd_next, load_c, done_c, tick_c, baud_en_c;
  logic                   wr_accept_c, wr_reject_c;
  logic                   unused_tx_data;

  // Upper TxData bits beyond DATA_BITS are intentionally dropped.
  assign unused_tx_data = ^TxData;

  assign baud_en_c   = (state_q != IDLE);
  assign wr_accept_c = TxWrite && tx_ready_q;
  assign wr_reject_c = TxWrite && !tx_ready_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .Clock (Clock),
    .Reset (Reset),
    .Enable(baud_en_c),
    .Tick  (tick_c)
  );

  // Next-state, shift/parity datapath and next line level.
  always_comb begin
    state_next   = state_q;
    shift_next   = shift_q;
    par_next     = par_q;
    bit_cnt_next = bit_cnt_q;
    load_c       = 1'b0;
    done_c       = 1'b0;
    txd_next     = 1'b1;

    case (state_q)
      IDLE: begin
        if (!tx_ready_q) begin
          state_next = START;
          load_c     = 1'b1;
        end
      end
      START: begin
        if (tick_c) state_next = DATA;
      end
      DATA: begin
        if (tick_c) begin
          shift_next = shift_q >> 1;
          par_next   = par_q ^ shift_q[0];
          if (bit_cnt_q == DATA_LAST) begin
            state_next = PAR_EN ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick_c) state_next = STOP;
      end
      STOP: begin
        if (tick_c) begin
          if (bit_cnt_q == STOP_LAST) begin
            done_c = 1'b1;
            if (!tx_ready_q) begin
              state_next = START;
              load_c     = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_cnt_next = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load_c) begin
      shift_next = hold_q;
      par_next   = 1'b0;
    end

    if (state_next != state_q) bit_cnt_next = '0;

    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PARITY:  txd_next = par_next ^ PAR_ODD;
      default: txd_next = 1'b1;
    endcase
  end

  // FSM and frame datapath registers; line driven straight from a flop.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      tx_d_q    <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_next;
      shift_q   <= shift_next;
      par_q     <= par_next;
      bit_cnt_q <= bit_cnt_next;
      tx_d_q    <= txd_next;
      tx_busy_q <= (state_next != IDLE);
    end
  end

  // Holding register, empty flag and sticky overrun.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      if (wr_accept_c) hold_q <= TxData[DATA_BITS-1:0];
      if (load_c) begin
        tx_ready_q <= 1'b1;
      end else if (wr_accept_c) begin
        tx_ready_q <= 1'b0;
      end
      if (wr_reject_c) overrun_q <= 1'b1;
    end
  end

  assign TxD       = tx_d_q;
  assign TxReady   = tx_ready_q;
  assign TxBusy    = tx_busy_q;
  assign TxDone    = done_c;
  assign TxOverrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations driven in parallel, checked against a frame-level model.
module tb_uart_tx_frame;

  localparam int NI  = 3;
  localparam int CPB = 4;
  localparam int CAP = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       txd [NI];
  logic       rdy [NI];
  logic       busy[NI];
  logic       done[NI];
  logic       ovr [NI];

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  // 0: 8E1, 1: 8O1, 2: 7N2
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e (
    .Clock(clk), .Reset(rst_n), .TxData(tx_data), .TxWrite(tx_write),
    .TxReady(rdy[0]), .TxD(txd[0]), .TxBusy(busy[0]), .TxDone(done[0]), .TxOverrun(ovr[0]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
    .Clock(clk), .Reset(rst_n), .TxData(tx_data), .TxWrite(tx_write),
    .TxReady(rdy[1]), .TxD(txd[1]), .TxBusy(busy[1]), .TxDone(done[1]), .TxOverrun(ovr[1]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_n (
    .Clock(clk), .Reset(rst_n), .TxData(tx_data), .TxWrite(tx_write),
    .TxReady(rdy[2]), .TxD(txd[2]), .TxBusy(busy[2]), .TxDone(done[2]), .TxOverrun(ovr[2]));

  function automatic int cfg_db(input int i); return (i == 2) ? 7 : 8; endfunction
  function automatic int cfg_pe(input int i); return (i == 2) ? 0 : 1; endfunction
  function automatic int cfg_po(input int i); return (i == 1) ? 1 : 0; endfunction
  function automatic int cfg_sb(input int i); return (i == 2) ? 2 : 1; endfunction

  function automatic int frame_len(input int i);
    return 1 + cfg_db(i) + cfg_pe(i) + cfg_sb(i);
  endfunction

  // Line level of bit slot s of a frame carrying d.
  function automatic logic frame_bit(input int i, input logic [7:0] d, input int s);
    int ones;
    ones = 0;
    for (int b = 0; b < cfg_db(i); b++) ones += int'(d[b]);
    if (s == 0) return 1'b0;
    if (s <= cfg_db(i)) return d[s-1];
    if (cfg_pe(i) == 1 && s == cfg_db(i) + 1) return 1'((ones % 2) ^ cfg_po(i));
    return 1'b1;
  endfunction

  // Reference model: one-entry queue feeding a line that replays whole frames.
  logic       m_ready [NI];
  logic       m_pend  [NI];
  logic       m_active[NI];
  logic       m_ovr   [NI];
  logic [7:0] m_hold  [NI];
  logic [7:0] m_cur   [NI];
  int         m_idx   [NI];
  logic       e_txd   [NI];
  logic       e_busy  [NI];
  logic       e_done  [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_ready[i] <= 1'b1; m_pend[i] <= 1'b0; m_active[i] <= 1'b0; m_ovr[i] <= 1'b0;
        m_hold[i] <= 8'h00; m_cur[i] <= 8'h00; m_idx[i] <= 0;
        e_txd[i] <= 1'b1; e_busy[i] <= 1'b0; e_done[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        logic act, pend_n, ready_n;
        logic [7:0] cur;
        int idx, last;
        act = m_active[i]; idx = m_idx[i]; cur = m_cur[i];
        pend_n = m_pend[i]; ready_n = m_ready[i];
        last = frame_len(i) * CPB - 1;
        if (!act && m_pend[i]) begin
          act = 1'b1; idx = 0; cur = m_hold[i]; pend_n = 1'b0; ready_n = 1'b1;
        end
        if (tx_write) begin
          if (m_ready[i]) begin
            m_hold[i] <= tx_data; pend_n = 1'b1; ready_n = 1'b0;
          end else begin
            m_ovr[i] <= 1'b1;
          end
        end
        if (act) begin
          e_txd[i]  <= frame_bit(i, cur, idx / CPB);
          e_busy[i] <= 1'b1;
          e_done[i] <= (idx == last);
          if (idx == last) act = 1'b0;
          idx++;
        end else begin
          e_txd[i] <= 1'b1; e_busy[i] <= 1'b0; e_done[i] <= 1'b0;
        end
        m_active[i] <= act; m_idx[i] <= idx; m_cur[i] <= cur;
        m_pend[i] <= pend_n; m_ready[i] <= ready_n;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < NI; i++) begin
        logic [4:0] got, exp;
        got = {txd[i], rdy[i], busy[i], done[i], ovr[i]};
        exp = {e_txd[i], m_ready[i], e_busy[i], e_done[i], m_ovr[i]};
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL model[%0d] t=%0t {txd,rdy,busy,done,ovr}: got %b expected %b", i, $time, got, exp);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // Capture per-interval outputs; interval c lies between rising edges c and c+1 after a write.
  logic cap_txd [NI][1:CAP];
  logic cap_busy[NI][1:CAP];
  logic cap_done[NI][1:CAP];
  logic cap_ovr [NI][1:CAP];

  task automatic write_byte(input logic [7:0] d);
    tx_data  = d;
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic capture(input int n, input int inj1, input logic [7:0] d1,
                         input int inj2, input logic [7:0] d2);
    for (int c = 1; c <= n; c++) begin
      tx_write = (c == inj1) || (c == inj2);
      tx_data  = (c == inj2) ? d2 : d1;
      @(negedge clk);
      tx_write = 1'b0;
      for (int i = 0; i < NI; i++) begin
        cap_txd[i][c] = txd[i]; cap_busy[i][c] = busy[i];
        cap_done[i][c] = done[i]; cap_ovr[i][c] = ovr[i];
      end
    end
  endtask

  function automatic int decode(input int i, input int base, input int nbits);
    int v;
    v = 0;
    for (int b = 0; b < nbits; b++) v |= int'(cap_txd[i][base + CPB*(b+1) + 2]) << b;
    return v;
  endfunction

  function automatic int count(input int i, input int lo, input int hi, input bit of_done);
    int n;
    n = 0;
    for (int c = lo; c <= hi; c++) n += of_done ? int'(cap_done[i][c]) : int'(cap_busy[i][c]);
    return n;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
    logic [6:0] data7;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 7'h25};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 7'h07};
    vecs[2] = '{8'h11, 1'b0, 1'b1, 7'h11};
    vecs[3] = '{8'h22, 1'b0, 1'b1, 7'h22};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 7'h7F};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 7'h00};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 7'h00};
    vecs[7] = '{8'h7E, 1'b0, 1'b1, 7'h7E};
    vecs[8] = '{8'h01, 1'b1, 1'b0, 7'h01};

    tx_write = 1'b0;
    tx_data  = 8'h00;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_outputs[%0d]", i), int'({txd[i], rdy[i], busy[i], done[i], ovr[i]}), 5'b11000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames from idle
    foreach (vecs[k]) begin
      write_byte(vecs[k].data);
      capture(48, 0, 8'h00, 0, 8'h00);
      chk($sformatf("e_start_latency[%0h]", vecs[k].data), int'(cap_txd[0][1]), 0);
      chk($sformatf("e_data[%0h]", vecs[k].data), decode(0, 0, 8), int'(vecs[k].data));
      chk($sformatf("e_parity[%0h]", vecs[k].data), int'(cap_txd[0][38]), int'(vecs[k].par_even));
      chk($sformatf("o_parity[%0h]", vecs[k].data), int'(cap_txd[1][38]), int'(vecs[k].par_odd));
      chk($sformatf("e_stop[%0h]", vecs[k].data), int'(cap_txd[0][42]), 1);
      chk($sformatf("n_data7[%0h]", vecs[k].data), decode(2, 0, 7), int'(vecs[k].data7));
      chk($sformatf("n_no_parity[%0h]", vecs[k].data), int'(cap_txd[2][34]), 1);
      chk($sformatf("e_len[%0h]", vecs[k].data), count(0, 1, 48, 1'b0), 44);
      chk($sformatf("n_len[%0h]", vecs[k].data), count(2, 1, 48, 1'b0), 40);
      chk($sformatf("e_done_at44[%0h]", vecs[k].data), int'(cap_done[0][44]), 1);
      chk($sformatf("e_done_once[%0h]", vecs[k].data), count(0, 1, 48, 1'b1), 1);
      chk($sformatf("n_done_at40[%0h]", vecs[k].data), int'(cap_done[2][40]), 1);
    end

    // Back-to-back: second byte queued during the first frame's data bits
    write_byte(8'h11);
    capture(96, 10, 8'h22, 0, 8'h00);
    chk("b2b_e_last_stop", int'(cap_txd[0][44]), 1);
    chk("b2b_e_done", int'(cap_done[0][44]), 1);
    chk("b2b_e_next_start", int'(cap_txd[0][45]), 0);
    chk("b2b_e_no_idle", count(0, 1, 88, 1'b0), 88);
    chk("b2b_e_first", decode(0, 0, 8), 8'h11);
    chk("b2b_e_second", decode(0, 44, 8), 8'h22);
    chk("b2b_n_next_start", int'(cap_txd[2][41]), 0);
    chk("b2b_n_second", decode(2, 40, 7), 8'h22);
    chk("b2b_e_overrun", int'(cap_ovr[0][96]), 0);

    // Three writes while busy with a full holding register
    write_byte(8'h33);
    capture(100, 10, 8'h44, 20, 8'h55);
    chk("ovr_before_third", int'(cap_ovr[0][15]), 0);
    chk("ovr_after_third", int'(cap_ovr[0][25]), 1);
    chk("ovr_sticky", int'(cap_ovr[0][100]), 1);
    chk("ovr_n_sticky", int'(cap_ovr[2][100]), 1);
    chk("ovr_frames_sent", count(0, 1, 100, 1'b1), 2);
    chk("ovr_first", decode(0, 0, 8), 8'h33);
    chk("ovr_second", decode(0, 44, 8), 8'h44);
    chk("ovr_busy_total", count(0, 1, 100, 1'b0), 88);

    // Reset pulsed in the middle of the data bits
    write_byte(8'h5A);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("midrst_txd[%0d]", i), int'(txd[i]), 1);
      chk($sformatf("midrst_busy[%0d]", i), int'(busy[i]), 0);
      chk($sformatf("midrst_ready[%0d]", i), int'(rdy[i]), 1);
      chk($sformatf("midrst_ovr[%0d]", i), int'(ovr[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    write_byte(8'hC3);
    capture(48, 0, 8'h00, 0, 8'h00);
    chk("post_rst_e_data", decode(0, 0, 8), 8'hC3);
    chk("post_rst_e_parity", int'(cap_txd[0][38]), 0);
    chk("post_rst_e_len", count(0, 1, 48, 1'b0), 44);
    chk("post_rst_n_data", decode(2, 0, 7), 8'h43);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tx_write = ($urandom_range(0, 15) == 0);
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_write = 1'b0;
    repeat (100) @(negedge clk);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
